// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master serial bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SID     = 2'd1,
    ST_CONNECT = 2'd2
  } bus_state_e;

  // Index of one of the two masters (0 or 1).
  typedef logic master_idx_t;

  localparam logic IDLE_LVL = 1'b1;

endpackage

// File: rtl/bus_arbiter_arb_pick.sv
// Grant selection: a split resume wins outright, otherwise arbitrate among eligible masters.
// On contention, ptr names the master that has priority.
module arb_pick
  import bus_pkg::*;
(
  input  logic [1:0]  req,
  input  logic [1:0]  split_mask,
  input  logic [1:0]  resume_req,
  input  master_idx_t ptr,
  output logic [1:0]  winner
);

  logic [1:0] elig;

  always_comb begin
    elig   = req & ~split_mask;
    winner = 2'b00;
    if (resume_req != 2'b00) begin
      winner = resume_req;
    end else if (elig == 2'b11) begin
      winner = ptr ? 2'b10 : 2'b01;
    end else begin
      winner = elig;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master serial bus arbiter: grant, serial slave-ID decode, connect, split/resume.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (master 0).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int SID_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            m_req,
  input  logic [1:0]            m_tx,
  output logic [1:0]            m_grant,
  output logic                  bus_tx,
  output logic [NUM_SLAVES-1:0] s_sel,
  input  logic [NUM_SLAVES-1:0] s_split,
  output logic                  busy,
  output logic                  decode_err,
  output bus_state_e            state_dbg
);

  localparam int CW = (SID_BITS > 1) ? $clog2(SID_BITS) : 1;

  bus_state_e            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d, spl_sel_q, spl_sel_d;
  logic [SID_BITS-1:0]   sid_q, sid_d, id_next;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d, spl_v_q, spl_v_d;
  master_idx_t           spl_m_q, spl_m_d, gm, ptr_q;
  logic [1:0]            spl_mask, resume_req, winner;
  logic                  cur_split;

  // Handshake: a master holds m_req high for its whole transaction; dropping it
  // ends the transaction. m_grant is the registered acknowledgement.
  assign gm         = grant_q[1];
  assign spl_mask   = spl_v_q ? (spl_m_q ? 2'b10 : 2'b01) : 2'b00;
  assign resume_req = (spl_v_q && m_req[spl_m_q] && !(|(s_split & spl_sel_q))) ? spl_mask : 2'b00;
  assign cur_split  = |(s_split & sel_q);
  assign id_next    = sid_q | (SID_BITS'(m_tx[gm]) << cnt_q);

  arb_pick u_pick (
    .req       (m_req),
    .split_mask(spl_mask),
    .resume_req(resume_req),
    .ptr       (ptr_q),
    .winner    (winner)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    sid_d     = sid_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    spl_v_d   = spl_v_q;
    spl_m_d   = spl_m_q;
    spl_sel_d = spl_sel_q;
    if (spl_v_q && !m_req[spl_m_q]) spl_v_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (winner != 2'b00) begin
          grant_d = winner;
          if (resume_req != 2'b00) begin
            state_d = ST_CONNECT;
            sel_d   = spl_sel_q;
            spl_v_d = 1'b0;
          end else begin
            state_d = ST_SID;
            sid_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_SID: begin
        if (!m_req[gm]) begin
          grant_d = 2'b00;
          sel_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(SID_BITS - 1)) begin
          if (int'(id_next) < NUM_SLAVES) begin
            sel_d   = NUM_SLAVES'(1) << id_next;
            state_d = ST_CONNECT;
          end else begin
            grant_d = 2'b00;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          sid_d = id_next;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CONNECT: begin
        // A split while another record is pending degrades to a plain release.
        if (m_req[gm] && cur_split && !spl_v_q) begin
          spl_v_d   = 1'b1;
          spl_m_d   = gm;
          spl_sel_d = sel_q;
        end
        if (!m_req[gm] || cur_split) begin
          grant_d = 2'b00;
          sel_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = 2'b00;
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      sel_q     <= '0;
      sid_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      spl_v_q   <= 1'b0;
      spl_m_q   <= 1'b0;
      spl_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      sid_q     <= sid_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      spl_v_q   <= spl_v_d;
      spl_m_q   <= spl_m_d;
      spl_sel_q <= spl_sel_d;
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // After each grant, priority passes to the master that was not granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= 1'b0;
    end else if (state_q == ST_IDLE && winner != 2'b00) begin
      ptr_q <= !winner[1];
    end
  end
`else
  assign ptr_q = 1'b0;
`endif

  assign m_grant    = grant_q;
  assign s_sel      = sel_q;
  assign decode_err = err_q;
  assign busy       = (state_q != ST_IDLE);
  assign bus_tx     = (state_q == ST_CONNECT) ? m_tx[gm] : IDLE_LVL;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: scoreboard of expected {grant, sel, decode_err} snapshots.
// Expectations follow BUS_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int NS = 3;
  localparam int SB = 2;
  localparam int W  = 6;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [1:0]      m_req = 2'b00;
  logic [1:0]      m_tx = 2'b11;
  logic [NS-1:0]   s_split = '0;
  logic [1:0]      m_grant;
  logic            bus_tx;
  logic [NS-1:0]   s_sel;
  logic            busy;
  logic            decode_err;
  bus_state_e      state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic rr_ptr = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  bus_arbiter #(.NUM_SLAVES(NS), .SID_BITS(SB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m_req     (m_req),
    .m_tx      (m_tx),
    .m_grant   (m_grant),
    .bus_tx    (bus_tx),
    .s_sel     (s_sel),
    .s_split   (s_split),
    .busy      (busy),
    .decode_err(decode_err),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  task automatic expect_out(input logic [1:0] g, input logic [NS-1:0] s, input logic e);
    exp_q.push_back({g, s, e});
  endtask

  task automatic observe(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) e = '1;
    else e = exp_q.pop_front();
    check(tag, {m_grant, s_sel, decode_err}, e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out"}, {m_grant, s_sel, decode_err, busy, bus_tx}, {2'b00, 3'b000, 1'b0, 1'b0, 1'b1});
    check({tag, "_st"}, state_dbg, ST_IDLE);
  endtask

  // model of arbitration priority
  function automatic logic [1:0] exp_winner(input logic [1:0] req);
    if (req == 2'b11) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      return rr_ptr ? 2'b10 : 2'b01;
`else
      return 2'b01;
`endif
    end
    return req;
  endfunction

  task automatic note_grant(input int m);
`ifdef BUS_ARB_ROUND_ROBIN_EN
    rr_ptr = (m == 0);
`else
    if (m > 1) $display("note: master index %0d out of range", m);
`endif
  endtask

  // drivers
  task automatic send_id(input int m, input int id);
    for (int b = 0; b < SB; b++) begin
      m_tx[m] = id[b];
      @(negedge clk);
    end
    m_tx[m] = 1'b1;
  endtask

  // Request for master m is already high; grant, then send the ID.
  task automatic do_txn(input int m, input int id, input string tag);
    logic [1:0] g;
    g = (m == 1) ? 2'b10 : 2'b01;
    expect_out(g, '0, 1'b0);
    @(negedge clk);
    observe({tag, "_grant"});
    check({tag, "_sid_bus"}, bus_tx, 1'b1);
    note_grant(m);
    if (id < NS) expect_out(g, NS'(1) << id, 1'b0);
    else expect_out(2'b00, '0, 1'b1);
    send_id(m, id);
    observe({tag, "_id"});
  endtask

  task automatic check_follow(input int m, input string tag);
    m_tx[m] = 1'b0;
    #1 check({tag, "_follow0"}, bus_tx, 1'b0);
    m_tx[m] = 1'b1;
    m_tx[1-m] = 1'b0;
    #1 check({tag, "_follow1"}, bus_tx, 1'b1);
    m_tx[1-m] = 1'b1;
  endtask

  task automatic release_all(input logic [1:0] keep, input string tag);
    m_req = keep;
    expect_out(2'b00, '0, 1'b0);
    @(negedge clk);
    observe(tag);
  endtask

  initial begin
    logic [1:0] w2;
    int w;

    #1 check_reset("por");
    @(negedge clk);
    rstn = 1'b1;

    // single master, ID 1
    @(negedge clk);
    m_req = 2'b01;
    do_txn(0, 1, "single");
    check("single_st", state_dbg, ST_CONNECT);
    check_follow(0, "single");
    release_all(2'b00, "single_rel");
    check("single_busy", busy, 1'b0);

    // contention
    m_req = 2'b11;
    for (int r = 0; r < 3; r++) begin
      w2 = exp_winner(2'b11);
      w = w2[1] ? 1 : 0;
      do_txn(w, r, $sformatf("cont%0d", r));
      m_req[w] = 1'b0;
      expect_out(2'b00, '0, 1'b0);
      @(negedge clk);
      observe($sformatf("cont%0d_rel", r));
      m_req[w] = 1'b1;
    end
    m_req = 2'b00;
    @(negedge clk);
    check("cont_idle", {m_grant, busy}, 3'b000);

    // invalid ID
    m_req = 2'b10;
    do_txn(1, 3, "decode");
    check("decode_st", state_dbg, ST_IDLE);
    m_req = 2'b00;
    @(negedge clk);
    check("decode_pulse", decode_err, 1'b0);
    check("decode_out", {m_grant, s_sel}, 5'b0);

    // split on slave 2, master 0 served, resume beats master 0
    m_req = 2'b10;
    do_txn(1, 2, "spl_m1");
    s_split[2] = 1'b1;
    release_all(2'b11, "spl_rel");
    do_txn(0, 0, "spl_m0");
    check_follow(0, "spl_m0");
    release_all(2'b10, "spl_m0_rel");
    m_req = 2'b11;
    s_split[2] = 1'b0;
    expect_out(2'b10, 3'b100, 1'b0);
    @(negedge clk);
    observe("resume");
    check("resume_st", state_dbg, ST_CONNECT);
    note_grant(1);
    check_follow(1, "resume");
    release_all(2'b01, "resume_rel");
    expect_out(2'b01, 3'b000, 1'b0);
    @(negedge clk);
    observe("m0_after");
    note_grant(0);
    release_all(2'b00, "m0_sid_drop");

    // record dropped when its master lets go of m_req
    m_req = 2'b10;
    do_txn(1, 2, "drop");
    s_split[2] = 1'b1;
    release_all(2'b10, "drop_split");
    m_req = 2'b00;
    @(negedge clk);
    s_split[2] = 1'b0;
    m_req = 2'b10;
    expect_out(2'b10, 3'b000, 1'b0);
    @(negedge clk);
    observe("no_resume");
    check("no_resume_st", state_dbg, ST_SID);
    note_grant(1);
    release_all(2'b00, "no_resume_rel");

    // reset during SID
    m_req = 2'b01;
    expect_out(2'b01, 3'b000, 1'b0);
    @(negedge clk);
    observe("rst_sid_grant");
    #2 rstn = 1'b0;
    #1 check_reset("rst_sid");
    m_req = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    rr_ptr = 1'b0;
`endif

    // reset during CONNECT with a split record pending
    @(negedge clk);
    m_req = 2'b10;
    do_txn(1, 2, "rst_m1");
    s_split[2] = 1'b1;
    release_all(2'b11, "rst_split");
    do_txn(0, 1, "rst_m0");
    #2 rstn = 1'b0;
    #1 check_reset("rst_conn");
    @(negedge clk);
    rstn = 1'b1;
    m_req = 2'b10;
    expect_out(2'b10, 3'b000, 1'b0);
    @(negedge clk);
    observe("rst_no_record");
    check("rst_no_record_st", state_dbg, ST_SID);
    s_split = '0;
    release_all(2'b00, "rst_end");

    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
